// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and default bit timing,
// used by both the transmitter and the receiver.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 217;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO with power-of-two depth; pointers wrap naturally and
// the occupancy count spans 0..DEPTH. Storage is not reset.
module uart_sync_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [7:0]    i_wdata,
  input  logic          i_pop,
  output logic [7:0]    o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  // A full FIFO refuses the write even when a pop frees a slot this cycle.
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1 framer with a registered
// line output. Define UART_TX_PARITY_EN to insert an even-parity bit before STOP.
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);

  uart_state_e   r_state;
  uart_state_e   w_next_state;
  logic [7:0]    r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          w_tx_level;
  logic          w_bit_done;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [7:0]    w_rdata;
  logic [CW-1:0] w_count;
`ifdef UART_TX_PARITY_EN
  logic          r_par;
`endif

  uart_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (tx_valid),
    .i_wdata (tx_data),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign tx_ready   = !w_full;
  assign tx_busy    = (r_state != ST_IDLE) || (w_count != '0);
  assign tx         = r_tx;
  assign w_bit_done = (r_cnt == LAST_CNT);

  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_next_state = ST_START;
        end
      end
      ST_START: if (w_bit_done) w_next_state = ST_DATA;
      ST_DATA: begin
        if (w_bit_done && (r_bit_idx == 3'd7))
`ifdef UART_TX_PARITY_EN
          w_next_state = ST_PARITY;
`else
          w_next_state = ST_STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: if (w_bit_done) w_next_state = ST_STOP;
`endif
      ST_STOP: begin
        // Chain straight into the next frame when more bytes are waiting.
        if (w_bit_done) begin
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_next_state = ST_START;
          end else begin
            w_next_state = ST_IDLE;
          end
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_tx_level = 1'b1;
    case (r_state)
      ST_START:  w_tx_level = 1'b0;
      ST_DATA:   w_tx_level = r_shift[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: w_tx_level = r_par;
`endif
      default:   w_tx_level = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_par     <= 1'b0;
`endif
    end else begin
      r_state <= w_next_state;
      r_tx    <= w_tx_level;
      if (w_pop) begin
        r_shift   <= w_rdata;
        r_cnt     <= '0;
        r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
        r_par     <= even_parity(w_rdata);
`endif
      end else if (r_state != ST_IDLE) begin
        if (w_bit_done) begin
          r_cnt <= '0;
          if (r_state == ST_DATA) begin
            r_shift   <= r_shift >> 1;
            r_bit_idx <= r_bit_idx + 3'd1;
          end
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Directed self-checking bench for uart_tx_buf: one fast instance (4 clk/bit)
// for framing/FIFO/reset scenarios and one at 16 clk/bit for serial loopback.
module tb_uart_tx_buf;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int C  = 4;
  localparam int F  = NB * C;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, tx, tx_busy;
  logic       lb_valid = 1'b0;
  logic [7:0] lb_data = 8'h00;
  logic       lb_ready, lb_tx, lb_busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_q0[$];
  logic [7:0] rx_q1[$];
  logic       rx_par_q[$];

  always #5 clk = ~clk;

  uart_tx_buf #(.CLKS_PER_BIT(C), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .tx(tx), .tx_busy(tx_busy)
  );

  uart_tx_buf #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4)) dut_lb (
    .clk(clk), .rst_n(rst_n), .tx_valid(lb_valid), .tx_data(lb_data),
    .tx_ready(lb_ready), .tx(lb_tx), .tx_busy(lb_busy)
  );

  // Reference receiver: samples mid-bit on falling clock edges.
  task automatic rx_run(input bit w, input int c);
    logic [7:0] b;
    logic       p;
    forever begin
      @(negedge clk);
      if (rst_n && ((w ? lb_tx : tx) === 1'b0)) begin
        repeat (c / 2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (c) @(negedge clk);
          b[k] = w ? lb_tx : tx;
        end
`ifdef UART_TX_PARITY_EN
        repeat (c) @(negedge clk);
        p = w ? lb_tx : tx;
        if (!w) rx_par_q.push_back(p);
`endif
        repeat (c) @(negedge clk);
        if ((w ? lb_tx : tx) === 1'b1) begin
          if (w) rx_q1.push_back(b);
          else   rx_q0.push_back(b);
        end
      end
    end
  endtask

  initial rx_run(1'b0, C);
  initial rx_run(1'b1, 16);

  task automatic wait_idle();
    int n = 0;
    while (tx_busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: tx_busy=%b required 0 within 2000 cycles", tx_busy);
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks += 4;
    if (tx !== 1'b1)       begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
    if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", tx_ready); end
    if (tx_busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
    if (lb_tx !== 1'b1)    begin errors++; $display("FAIL reset_lb_tx: got %b want 1", lb_tx); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks += 3;
    if (tx !== 1'b1)       begin errors++; $display("FAIL post_reset_tx: got %b want 1", tx); end
    if (tx_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", tx_ready); end
    if (tx_busy !== 1'b0)  begin errors++; $display("FAIL post_reset_busy: got %b want 0", tx_busy); end
  endtask

  task automatic test_single_byte();
    logic [10:0] exp;
`ifdef UART_TX_PARITY_EN
    exp = {1'b1, 1'b0, 8'hA5, 1'b0};
`else
    exp = {1'b0, 1'b1, 8'hA5, 1'b0};
`endif
    wait_idle();
    rx_q0.delete();
    @(negedge clk); tx_valid = 1'b1; tx_data = 8'hA5;
    @(negedge clk); tx_valid = 1'b0;
    @(negedge clk);
    checks += 2;
    if (tx !== 1'b1)      begin errors++; $display("FAIL single_n1_tx: got %b want 1", tx); end
    if (tx_busy !== 1'b1) begin errors++; $display("FAIL single_n1_busy: got %b want 1", tx_busy); end
    for (int i = 0; i < F; i++) begin
      @(negedge clk);
      checks++;
      if (tx !== exp[i / C]) begin
        errors++;
        $display("FAIL single_bit cycle %0d: tx=%b want %b", i, tx, exp[i / C]);
      end
    end
    @(negedge clk);
    checks += 4;
    if (tx !== 1'b1)      begin errors++; $display("FAIL single_end_tx: got %b want 1", tx); end
    if (tx_busy !== 1'b0) begin errors++; $display("FAIL single_end_busy: got %b want 0", tx_busy); end
    if (rx_q0.size() != 1) begin
      errors++; $display("FAIL single_rx_count: got %0d want 1", rx_q0.size());
    end
    if (rx_q0.size() > 0 && rx_q0[0] !== 8'hA5) begin
      errors++; $display("FAIL single_rx_byte: got %h want a5", rx_q0[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [21:0] exp;
`ifdef UART_TX_PARITY_EN
    exp = {1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
`else
    exp = {2'b00, 1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0};
`endif
    wait_idle();
    rx_q0.delete();
    @(negedge clk); tx_valid = 1'b1; tx_data = 8'h00;
    @(negedge clk); tx_data = 8'hFF;
    @(negedge clk); tx_valid = 1'b0;
    for (int i = 0; i < 2 * F; i++) begin
      @(negedge clk);
      checks++;
      if (tx !== exp[i / C]) begin
        errors++;
        $display("FAIL b2b_bit cycle %0d: tx=%b want %b", i, tx, exp[i / C]);
      end
      if (i < 2 * F - 1) begin
        checks++;
        if (tx_busy !== 1'b1) begin
          errors++; $display("FAIL b2b_busy cycle %0d: got %b want 1", i, tx_busy);
        end
      end
    end
    @(negedge clk);
    checks += 2;
    if (tx_busy !== 1'b0) begin errors++; $display("FAIL b2b_end_busy: got %b want 0", tx_busy); end
    if (rx_q0.size() != 2) begin
      errors++; $display("FAIL b2b_rx_count: got %0d want 2", rx_q0.size());
    end
  endtask

  task automatic test_full_fifo();
    logic [7:0] arr [6];
    int idx = 0, cyc = 0, low_cyc = -1, low_idx = -1, n = 0;
    arr[0] = 8'h11; arr[1] = 8'h22; arr[2] = 8'h33;
    arr[3] = 8'h44; arr[4] = 8'h55; arr[5] = 8'h66;
    wait_idle();
    rx_q0.delete();
    while (idx < 6 && cyc < 500) begin
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = arr[idx];
      if (!tx_ready && low_cyc < 0) begin
        low_cyc = cyc;
        low_idx = idx;
      end
      if (tx_ready) begin
        @(posedge clk);
        idx++;
      end
      cyc++;
    end
    @(negedge clk); tx_valid = 1'b0;
    checks += 3;
    if (idx != 6)     begin errors++; $display("FAIL full_accepts: got %0d want 6", idx); end
    if (low_idx != 5) begin errors++; $display("FAIL full_ready_drop_after: got %0d accepts want 5", low_idx); end
    if (low_cyc != 5) begin errors++; $display("FAIL full_ready_drop_cycle: got %0d want 5", low_cyc); end
    while (rx_q0.size() < 6 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rx_q0.size() != 6) begin
      errors++; $display("FAIL full_rx_count: got %0d want 6", rx_q0.size());
    end
    for (int i = 0; i < 6 && i < rx_q0.size(); i++) begin
      checks++;
      if (rx_q0[i] !== arr[i]) begin
        errors++; $display("FAIL full_rx_byte %0d: got %h want %h", i, rx_q0[i], arr[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int n = 0;
    wait_idle();
    @(negedge clk); tx_valid = 1'b1; tx_data = 8'h3C;
    @(negedge clk); tx_valid = 1'b0;
    @(negedge clk);
    repeat (18) @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL mid_bit3_level: got %b want 1", tx); end
    #1 rst_n = 1'b0;
    #1;
    checks += 3;
    if (tx !== 1'b1)       begin errors++; $display("FAIL mid_reset_tx: got %b want 1", tx); end
    if (tx_busy !== 1'b0)  begin errors++; $display("FAIL mid_reset_busy: got %b want 0", tx_busy); end
    if (tx_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready: got %b want 1", tx_ready); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (tx !== 1'b1) begin errors++; $display("FAIL mid_reset_hold %0d: got %b want 1", i, tx); end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      checks++;
      if (tx !== 1'b1) begin errors++; $display("FAIL mid_after_release %0d: got %b want 1", i, tx); end
    end
    rx_q0.delete();
    tx_valid = 1'b1; tx_data = 8'h96;
    @(negedge clk); tx_valid = 1'b0;
    while (rx_q0.size() < 1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rx_q0.size() != 1) begin
      errors++; $display("FAIL mid_next_count: got %0d want 1", rx_q0.size());
    end else begin
      checks++;
      if (rx_q0[0] !== 8'h96) begin
        errors++; $display("FAIL mid_next_byte: got %h want 96", rx_q0[0]);
      end
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    wait_idle();
    rx_par_q.delete();
    @(negedge clk); tx_valid = 1'b1; tx_data = 8'h07;
    @(negedge clk); tx_data = 8'h03;
    @(negedge clk); tx_valid = 1'b0;
    for (int i = 0; i < 89; i++) begin
      @(negedge clk);
      if (i == 37 || i == 43 || i == 44 || i == 81 || i == 87) begin
        checks++;
        if (tx !== ((i == 44 || i == 81) ? 1'b0 : 1'b1)) begin
          errors++; $display("FAIL parity_line cycle %0d: got %b", i, tx);
        end
      end
    end
    checks += 2;
    if (tx_busy !== 1'b0) begin errors++; $display("FAIL parity_end_busy: got %b want 0", tx_busy); end
    if (rx_par_q.size() != 2) begin
      errors++; $display("FAIL parity_rx_count: got %0d want 2", rx_par_q.size());
    end else begin
      checks += 2;
      if (rx_par_q[0] !== 1'b1) begin errors++; $display("FAIL parity_07: got %b want 1", rx_par_q[0]); end
      if (rx_par_q[1] !== 1'b0) begin errors++; $display("FAIL parity_03: got %b want 0", rx_par_q[1]); end
    end
  endtask
`endif

  task automatic test_loopback();
    int sent = 0, cyc = 0, n = 0;
    rx_q1.delete();
    while (sent < 256 && cyc < 60000) begin
      @(negedge clk);
      lb_valid = 1'b1;
      lb_data  = sent[7:0];
      if (lb_ready) begin
        @(posedge clk);
        sent++;
      end
      cyc++;
    end
    @(negedge clk); lb_valid = 1'b0;
    while (rx_q1.size() < 256 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rx_q1.size() != 256) begin
      errors++; $display("FAIL loop_count: got %0d want 256 (sent %0d)", rx_q1.size(), sent);
    end
    for (int i = 0; i < 256 && i < rx_q1.size(); i++) begin
      checks++;
      if (rx_q1[i] !== 8'(i)) begin
        errors++; $display("FAIL loop_byte %0d: got %h want %h", i, rx_q1[i], 8'(i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_full_fifo();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_loopback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_buf.md
UART_TX_BUF -- requirements
Module: uart_tx_buf

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 217, giving clk cycles per serial bit (valid range 4..255).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving the byte buffer depth (power of two, 2..16).
REQ-003 The block SHALL have one clock and an asynchronous active-low reset: clk in 1, rising-edge clock for all logic.
REQ-004 The block SHALL have rst_n in 1, asynchronous active-low reset.
REQ-005 The block SHALL have tx_valid in 1, the upstream byte-offer qualifier.
REQ-006 The block SHALL have tx_data in 8, the byte offered with tx_valid.
REQ-007 The block SHALL have tx_ready out 1, high when a byte can be accepted.
REQ-008 The block SHALL have tx out 1, the registered serial line, idle high.
REQ-009 The block SHALL have tx_busy out 1, high while any byte is buffered or being shifted out.

Function
REQ-010 A byte SHALL be accepted on a rising edge where tx_valid and tx_ready are both high; tx_ready SHALL equal not-full of the FIFO, independent of tx_valid.
REQ-011 When the FIFO is full, tx_ready SHALL be low even if a pop occurs in the same cycle; the offered byte is not written.
REQ-012 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH, and the occupancy count SHALL be FIFO_DEPTH-bit-exact (0..FIFO_DEPTH).
REQ-013 The FSM SHALL have states IDLE, START, DATA, PARITY (macro only), and STOP.
REQ-014 In IDLE with a non-empty FIFO, the FSM SHALL pop one byte, load the shift register, and enter START, with tx low from the next edge.
REQ-015 A byte accepted at edge N into an empty FIFO while IDLE SHALL drive tx low from edge N+2.
REQ-016 START, each DATA bit, PARITY, and STOP SHALL each hold tx for exactly CLKS_PER_BIT cycles, counted by an 8-bit counter reset to 0 on every bit boundary.
REQ-017 Data bits SHALL be sent LSB first; after bit 7, the FSM SHALL go to PARITY if enabled, else STOP; the STOP level is 1.
REQ-018 On the last STOP cycle with a non-empty FIFO, the FSM SHALL pop and go directly to START with no idle gap; otherwise it SHALL go to IDLE.
REQ-019 A frame without parity SHALL last exactly 10*CLKS_PER_BIT cycles.
REQ-020 tx_busy SHALL be high when state is not IDLE or the FIFO is non-empty.
REQ-021 Simultaneous push and pop with a non-full FIFO SHALL leave the count unchanged and preserve order.
REQ-022 Illegal state encodings SHALL return to IDLE with tx high.

Reset
REQ-023 Asserting rst_n low SHALL immediately force state IDLE, tx=1, and counters, pointers, and count to 0; this gives tx_ready=1 and tx_busy=0.
REQ-024 Reset mid-frame SHALL abort the frame and discard buffered bytes; tx SHALL return high without glitching low.
REQ-025 FIFO storage contents SHALL need no reset.

Configuration
REQ-026 With macro UART_TX_PARITY_EN defined, an even-parity bit (XOR of the 8 data bits) SHALL be sent between bit 7 and STOP, and a frame SHALL be 11*CLKS_PER_BIT cycles.
REQ-027 Without UART_TX_PARITY_EN, the PARITY state and its logic SHALL be absent.

Structure
REQ-028 State encodings (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4) and the default CLKS_PER_BIT SHALL be defined in shared package uart_pkg, which the receiver also uses.
REQ-029 The buffer SHALL be a sub-module uart_sync_fifo (push/pop/full/empty/count); the FSM and shifter SHALL stay in uart_tx_buf.

Verification
REQ-030 The bench SHALL check a single byte: CLKS_PER_BIT=4, push 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles, tx low from edge N+2.
REQ-031 The bench SHALL check back-to-back bytes: push 0x00 then 0xFF on consecutive cycles -> two 40-cycle frames with no idle gap, and tx_busy low only after the second stop bit.
REQ-032 The bench SHALL check a full FIFO: FIFO_DEPTH=4, hold tx_valid with 6 bytes -> tx_ready drops after the 5th accept (1 popped plus 4 buffered), and no byte is lost or duplicated.
REQ-033 The bench SHALL check reset mid-frame: assert rst_n low during DATA bit 3 -> tx=1 and tx_busy=0 immediately, and the next pushed byte is sent cleanly.
REQ-034 The bench SHALL check parity with UART_TX_PARITY_EN: push 0x07 -> parity bit 1; push 0x03 -> parity bit 0; frames are 44 cycles each.
REQ-035 The bench SHALL check loopback: connect tx to the team's receiver at CLKS_PER_BIT=16, send 0x00..0xFF -> every received byte matches the sent byte, in order.
